vidbuf_wr_arb: RTL and testbench

- Write-side controller for the dual-clock video frame buffer (512x256, 24-bit RGB, address {y,x}).
- Shares the single buffer write port between two requesters:
  - a single-pixel streaming port (CPU or decoder, valid/ready);
  - an internal rectangle-fill engine (start/busy/done).
- Sits in the write clock domain; its registered wr_* outputs drive the frame buffer's x/y/data/we inputs directly.

---
 rtl/vidbuf_wr_arb.sv | 137 +++++++++++++
 tb/tb_vidbuf_wr_arb.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/vidbuf_wr_arb.sv
// rtl/vidbuf_wr_arb.sv - frame-buffer write-port arbiter: pixel stream vs. rectangle-fill engine
// Optional power-on clear of the whole buffer: define VIDBUF_CLEAR_ON_RESET_EN.
module vidbuf_wr_arb #(
  parameter int              XW          = 9,
  parameter int              YW          = 8,
  parameter int              DW          = 24,
  parameter logic [DW-1:0]   CLEAR_COLOR = 24'h000000
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          px_valid,
  output logic          px_ready,
  input  logic [XW-1:0] px_x,
  input  logic [YW-1:0] px_y,
  input  logic [DW-1:0] px_data,
  input  logic          fill_start,
  input  logic [XW-1:0] fill_x0,
  input  logic [XW-1:0] fill_x1,
  input  logic [YW-1:0] fill_y0,
  input  logic [YW-1:0] fill_y1,
  input  logic [DW-1:0] fill_color,
  output logic          fill_busy,
  output logic          fill_done,
  output logic [XW-1:0] wr_x,
  output logic [YW-1:0] wr_y,
  output logic [DW-1:0] wr_data,
  output logic          wr_we
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_DONE  = 2'd2
`ifdef VIDBUF_CLEAR_ON_RESET_EN
    , ST_CLEAR = 2'd3
`endif
  } state_t;

  state_t        state_q, state_d;
  logic [XW-1:0] xmin_q, xmax_q, cx_q;
  logic [YW-1:0] ymax_q, cy_q;
  logic [DW-1:0] color_q;
  logic          last_fill_q;
  logic          eng_gnt;
  logic          eng_last;

  assign eng_last = (cx_q == xmax_q) && (cy_q == ymax_q);

  always_comb begin
    state_d   = state_q;
    px_ready  = 1'b0;
    eng_gnt   = 1'b0;
    fill_busy = 1'b0;
    fill_done = 1'b0;
    if (!RST) begin
      case (state_q)
        ST_IDLE: begin
          px_ready = px_valid;
          if (fill_start) state_d = ST_FILL;
        end
        ST_FILL: begin
          fill_busy = 1'b1;
          // Contested cycle goes to whoever was not served last.
          px_ready  = px_valid && last_fill_q;
          eng_gnt   = !px_ready;
          if (eng_gnt && eng_last) state_d = ST_DONE;
        end
        ST_DONE: begin
          fill_done = 1'b1;
          px_ready  = px_valid;
          state_d   = ST_IDLE;
        end
`ifdef VIDBUF_CLEAR_ON_RESET_EN
        ST_CLEAR: begin
          fill_busy = 1'b1;
          eng_gnt   = 1'b1;
          if (eng_last) state_d = ST_IDLE;
        end
`endif
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
`ifdef VIDBUF_CLEAR_ON_RESET_EN
      state_q <= ST_CLEAR;
`else
      state_q <= ST_IDLE;
`endif
      // Reset bounds describe the whole buffer so the clear reuses the fill walker.
      xmin_q      <= '0;
      xmax_q      <= '1;
      ymax_q      <= '1;
      cx_q        <= '0;
      cy_q        <= '0;
      color_q     <= CLEAR_COLOR;
      last_fill_q <= 1'b1;
      wr_x        <= '0;
      wr_y        <= '0;
      wr_data     <= '0;
      wr_we       <= 1'b0;
    end else begin
      state_q <= state_d;
      wr_we   <= 1'b0;
      if (px_ready) begin
        wr_x        <= px_x;
        wr_y        <= px_y;
        wr_data     <= px_data;
        wr_we       <= 1'b1;
        last_fill_q <= 1'b0;
      end else if (eng_gnt) begin
        wr_x        <= cx_q;
        wr_y        <= cy_q;
        wr_data     <= color_q;
        wr_we       <= 1'b1;
        last_fill_q <= 1'b1;
        if (cx_q == xmax_q) begin
          cx_q <= xmin_q;
          cy_q <= cy_q + YW'(1);
        end else begin
          cx_q <= cx_q + XW'(1);
        end
      end
      if (state_q == ST_IDLE && fill_start) begin
        xmin_q  <= (fill_x0 > fill_x1) ? fill_x1 : fill_x0;
        cx_q    <= (fill_x0 > fill_x1) ? fill_x1 : fill_x0;
        xmax_q  <= (fill_x0 > fill_x1) ? fill_x0 : fill_x1;
        cy_q    <= (fill_y0 > fill_y1) ? fill_y1 : fill_y0;
        ymax_q  <= (fill_y0 > fill_y1) ? fill_y0 : fill_y1;
        color_q <= fill_color;
      end
    end
  end

endmodule

// File: tb/tb_vidbuf_wr_arb.sv
// tb/tb_vidbuf_wr_arb.sv - directed bench for vidbuf_wr_arb with expected-write scoreboard
module tb_vidbuf_wr_arb;
  localparam int XW = 9;
  localparam int YW = 8;
  localparam int DW = 24;

  logic          CLK = 1'b0;
  logic          RST;
  logic          px_valid, px_ready;
  logic [XW-1:0] px_x;
  logic [YW-1:0] px_y;
  logic [DW-1:0] px_data;
  logic          fill_start;
  logic [XW-1:0] fill_x0, fill_x1;
  logic [YW-1:0] fill_y0, fill_y1;
  logic [DW-1:0] fill_color;
  logic          fill_busy, fill_done;
  logic [XW-1:0] wr_x;
  logic [YW-1:0] wr_y;
  logic [DW-1:0] wr_data;
  logic          wr_we;

  typedef struct packed {
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic [DW-1:0] d;
  } wr_t;

  wr_t exp_q[$];
  int  n_cmp = 0;
  int  n_bad = 0;

  vidbuf_wr_arb #(.XW(XW), .YW(YW), .DW(DW), .CLEAR_COLOR(24'h000000)) dut (
    .CLK(CLK), .RST(RST),
    .px_valid(px_valid), .px_ready(px_ready), .px_x(px_x), .px_y(px_y), .px_data(px_data),
    .fill_start(fill_start), .fill_x0(fill_x0), .fill_x1(fill_x1),
    .fill_y0(fill_y0), .fill_y1(fill_y1), .fill_color(fill_color),
    .fill_busy(fill_busy), .fill_done(fill_done),
    .wr_x(wr_x), .wr_y(wr_y), .wr_data(wr_data), .wr_we(wr_we)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic sample();
    @(negedge CLK);
    #1;
  endtask

  task automatic push(input int x, input int y, input logic [DW-1:0] d);
    wr_t e;
    e.x = XW'(x);
    e.y = YW'(y);
    e.d = d;
    exp_q.push_back(e);
  endtask

  always @(negedge CLK) begin : monitor
    wr_t e;
    if (wr_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_write", 32'(wr_we), 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("wr_x", 32'(wr_x), 32'(e.x));
        check("wr_y", 32'(wr_y), 32'(e.y));
        check("wr_data", 32'(wr_data), 32'(e.d));
      end
    end
  end

  task automatic run_fill(input int x0, input int x1, input int y0, input int y1,
                          input logic [DW-1:0] color);
    int xmin, xmax, ymin, ymax, n;
    xmin = (x0 > x1) ? x1 : x0;
    xmax = (x0 > x1) ? x0 : x1;
    ymin = (y0 > y1) ? y1 : y0;
    ymax = (y0 > y1) ? y0 : y1;
    n = (xmax - xmin + 1) * (ymax - ymin + 1);
    tick();
    fill_start = 1'b1;
    fill_x0 = XW'(x0); fill_x1 = XW'(x1);
    fill_y0 = YW'(y0); fill_y1 = YW'(y1);
    fill_color = color;
    for (int y = ymin; y <= ymax; y++)
      for (int x = xmin; x <= xmax; x++)
        push(x, y, color);
    sample();
    check("fill_busy_at_start", 32'(fill_busy), 32'd0);
    for (int i = 1; i <= n; i++) begin
      tick();
      fill_start = 1'b0;
      sample();
      check("fill_busy_running", 32'(fill_busy), 32'd1);
      check("fill_done_running", 32'(fill_done), 32'd0);
      if (i > 1) check("fill_back_to_back", 32'(wr_we), 32'd1);
    end
    tick();
    sample();
    check("fill_done_pulse", 32'(fill_done), 32'd1);
    check("fill_busy_at_done", 32'(fill_busy), 32'd0);
    check("last_write_we", 32'(wr_we), 32'd1);
    check("last_write_x", 32'(wr_x), 32'(xmax));
    check("last_write_y", 32'(wr_y), 32'(ymax));
    tick();
    sample();
    check("fill_done_clear", 32'(fill_done), 32'd0);
    check("no_write_after_fill", 32'(wr_we), 32'd0);
    check("fill_queue_empty", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    logic [XW-1:0] pxx [3];
    logic [DW-1:0] pxd [3];
    logic [4:0]    rdy_exp;
    int            pi;

    RST = 1'b1;
    px_valid = 1'b1; px_x = '0; px_y = '0; px_data = '0;
    fill_start = 1'b0; fill_x0 = '0; fill_x1 = '0; fill_y0 = '0; fill_y1 = '0; fill_color = '0;
    tick();
    tick();
    sample();
    check("rst_px_ready", 32'(px_ready), 32'd0);
    check("rst_wr_we", 32'(wr_we), 32'd0);
    check("rst_fill_busy", 32'(fill_busy), 32'd0);
    check("rst_fill_done", 32'(fill_done), 32'd0);
    check("rst_wr_x", 32'(wr_x), 32'd0);
    check("rst_wr_data", 32'(wr_data), 32'd0);
    tick();
    RST = 1'b0;
    px_valid = 1'b0;

    // single pixel, idle engine
    tick();
    px_valid = 1'b1; px_x = 9'd3; px_y = 8'd5; px_data = 24'hFF0000;
    push(3, 5, 24'hFF0000);
    sample();
    check("pixel_ready", 32'(px_ready), 32'd1);
    tick();
    px_valid = 1'b0;
    sample();
    check("pixel_we", 32'(wr_we), 32'd1);
    tick();
    sample();
    check("pixel_we_drop", 32'(wr_we), 32'd0);
    check("pixel_x_hold", 32'(wr_x), 32'd3);
    check("idle_ready_low", 32'(px_ready), 32'd0);

    run_fill(10, 12, 4, 5, 24'h00FF00);
    run_fill(12, 10, 5, 4, 24'h00FF00);

    // contention: 4x1 fill against three back-to-back pixels
    pxx[0] = 9'd1; pxx[1] = 9'd2; pxx[2] = 9'd3;
    pxd[0] = 24'hAA0001; pxd[1] = 24'hAA0002; pxd[2] = 24'hAA0003;
    rdy_exp = 5'b10101;
    tick();
    fill_start = 1'b1;
    fill_x0 = 9'd20; fill_x1 = 9'd23; fill_y0 = 8'd7; fill_y1 = 8'd7; fill_color = 24'h0000FF;
    push(1, 1, pxd[0]); push(20, 7, 24'h0000FF);
    push(2, 2, pxd[1]); push(21, 7, 24'h0000FF);
    push(3, 3, pxd[2]); push(22, 7, 24'h0000FF);
    push(23, 7, 24'h0000FF);
    pi = 0;
    for (int k = 0; k < 5; k++) begin
      tick();
      if (k == 2) begin
        fill_start = 1'b1;
        fill_x0 = 9'd0; fill_x1 = 9'd5; fill_y0 = 8'd0; fill_y1 = 8'd5;
      end else begin
        fill_start = 1'b0;
      end
      px_valid = 1'b1; px_x = pxx[pi]; px_y = YW'(pxx[pi]); px_data = pxd[pi];
      sample();
      check("contend_px_ready", 32'(px_ready), 32'(rdy_exp[4-k]));
      check("contend_fill_busy", 32'(fill_busy), 32'd1);
      if (rdy_exp[4-k]) pi++;
    end
    tick();
    px_valid = 1'b0; fill_start = 1'b0;
    sample();
    check("contend_ready_idle", 32'(px_ready), 32'd0);
    tick();
    sample();
    check("contend_busy_last", 32'(fill_busy), 32'd1);
    tick();
    sample();
    check("contend_done", 32'(fill_done), 32'd1);
    check("contend_last_x", 32'(wr_x), 32'd23);
    for (int i = 0; i < 6; i++) tick();
    sample();
    check("contend_queue_empty", 32'(exp_q.size()), 32'd0);
    check("contend_no_refill", 32'(fill_busy), 32'd0);

    // reset after the third write of a 10x10 fill
    tick();
    fill_start = 1'b1;
    fill_x0 = 9'd100; fill_x1 = 9'd109; fill_y0 = 8'd50; fill_y1 = 8'd59; fill_color = 24'h445566;
    push(100, 50, 24'h445566); push(101, 50, 24'h445566); push(102, 50, 24'h445566);
    tick();
    fill_start = 1'b0;
    tick();
    tick();
    tick();
    RST = 1'b1;
    sample();
    check("rstfill_third_we", 32'(wr_we), 32'd1);
    tick();
    RST = 1'b0;
    sample();
    check("rstfill_wr_x_cleared", 32'(wr_x), 32'd0);
    for (int i = 0; i < 10; i++) begin
      check("rstfill_we_low", 32'(wr_we), 32'd0);
      check("rstfill_busy_low", 32'(fill_busy), 32'd0);
      check("rstfill_no_done", 32'(fill_done), 32'd0);
      tick();
      sample();
    end
    check("rstfill_queue_empty", 32'(exp_q.size()), 32'd0);

    // 1x1 fill after reset
    tick();
    fill_start = 1'b1;
    fill_x0 = 9'd7; fill_x1 = 9'd7; fill_y0 = 8'd9; fill_y1 = 8'd9; fill_color = 24'h123456;
    push(7, 9, 24'h123456);
    tick();
    fill_start = 1'b0;
    sample();
    check("one_busy", 32'(fill_busy), 32'd1);
    check("one_done_early", 32'(fill_done), 32'd0);
    tick();
    sample();
    check("one_done", 32'(fill_done), 32'd1);
    check("one_we", 32'(wr_we), 32'd1);
    check("one_busy_off", 32'(fill_busy), 32'd0);
    tick();
    sample();
    check("one_single_write", 32'(wr_we), 32'd0);

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick();
    check("final_queue_drained", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
